tx_frame_source: RTL and testbench

Synthesizable, parametrised successor to the byte-level TX source. It accepts complete frames from the application layer into an internal word FIFO and replays them over the tx_interface handshake (data, data_bits, data_valid, req). Operation is store-and-forward: a frame is only presented to the serialiser once its last word is buffered, so the serialiser never underruns mid-frame. It sits between the ISO/IEC 14443A protocol logic and the TX serialiser.

---
 rtl/tx_frame_source.sv | 189 ++++++++++++++++++
 tb/tb_tx_frame_source.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_source.sv
// tx_frame_source: store-and-forward frame buffer between the ISO/IEC 14443A
// protocol logic and the TX serialiser. Frames are written word by word into
// a circular FIFO and only replayed once their last word is stored.
// Optional feature: define TX_FRAME_SOURCE_FLUSH_EN to add the flush input.
// Read handshake: data/data_bits are meaningful while data_valid is high; a
// single-cycle req while data_valid is high consumes the current word and the
// next word (or data_valid = 0) appears after that same edge. req while
// data_valid is low is ignored. Write handshake: a word is taken on any edge
// where wr_valid && wr_ready.
module tx_frame_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 32,
  localparam int BW = $clog2(DATA_WIDTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BW-1:0]         wr_first_bits,
  input  logic                  wr_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic [BW-1:0]         data_bits,
  output logic                  data_valid,
  input  logic                  req,
  output logic [CW-1:0]         frames_pending,
  output logic                  overflow
`ifdef TX_FRAME_SOURCE_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  localparam int AW = CW - 1;
  localparam int EW = DATA_WIDTH + 1 + BW;

  typedef enum logic {IDLE, SEND} state_t;

  // Entry layout: {data, last, bits}
  logic [EW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [CW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, rd_inc;
  logic [CW-1:0] frame_start, frame_start_d, count;
  logic          first_pend, first_d;
  logic          dropping, dropping_d, overflow_d;
  logic          accept, store, pend_inc, pend_dec, load, out_last, full;
  logic          flush_req;
  logic [EW-1:0] wr_entry, next_entry, load_entry;

`ifdef TX_FRAME_SOURCE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == CW'(DEPTH));
  assign wr_ready   = !full || dropping;
  assign data_valid = (state_q == SEND);
  assign rd_inc     = rd_ptr + 1'b1;
  // A word written on the same edge it is needed is forwarded from the input.
  assign next_entry = (store && (wr_ptr == rd_inc)) ? wr_entry : mem[rd_inc[AW-1:0]];

  // Writer side: framing, overflow recovery and frame completion.
  always_comb begin
    accept        = wr_valid && wr_ready && !flush_req;
    store         = 1'b0;
    wr_ptr_d      = wr_ptr;
    frame_start_d = frame_start;
    first_d       = first_pend;
    dropping_d    = dropping;
    overflow_d    = overflow;
    pend_inc      = 1'b0;
    wr_entry      = {wr_data, wr_last, (first_pend ? wr_first_bits : BW'(0))};
    if (accept) begin
      if (dropping) begin
        // Swallow the rest of the over-long frame, including its last word.
        if (wr_last) begin
          dropping_d = 1'b0;
          first_d    = 1'b1;
        end
      end else if (wr_last) begin
        store         = 1'b1;
        wr_ptr_d      = wr_ptr + 1'b1;
        frame_start_d = wr_ptr + 1'b1;
        first_d       = 1'b1;
        pend_inc      = 1'b1;
      end else if ((count == CW'(DEPTH - 1)) && (frames_pending == '0)) begin
        // The frame can never fit: rewind to its start and drop it.
        overflow_d = 1'b1;
        dropping_d = 1'b1;
        wr_ptr_d   = frame_start;
        first_d    = 1'b1;
      end else begin
        store    = 1'b1;
        wr_ptr_d = wr_ptr + 1'b1;
        first_d  = 1'b0;
      end
    end
    if (flush_req) begin
      wr_ptr_d      = '0;
      frame_start_d = '0;
      first_d       = 1'b1;
      dropping_d    = 1'b0;
    end
  end

  // Read FSM: next state, pop and output-register load decisions.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr;
    pend_dec   = 1'b0;
    load       = 1'b0;
    load_entry = next_entry;
    case (state_q)
      IDLE: begin
        if (frames_pending != '0) begin
          load       = 1'b1;
          load_entry = mem[rd_ptr[AW-1:0]];
          state_d    = SEND;
        end
      end
      SEND: begin
        if (req) begin
          rd_ptr_d = rd_inc;
          pend_dec = out_last;
          // Stay in SEND mid-frame, or when another complete frame remains.
          if (!out_last || (frames_pending != CW'(1)) || pend_inc) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_req) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      pend_dec = 1'b0;
      load     = 1'b0;
    end
  end

  // State, pointers, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      frame_start    <= '0;
      first_pend     <= 1'b1;
      dropping       <= 1'b0;
      overflow       <= 1'b0;
      frames_pending <= '0;
      data           <= '0;
      data_bits      <= '0;
      out_last       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      frame_start <= frame_start_d;
      first_pend  <= first_d;
      dropping    <= dropping_d;
      overflow    <= overflow_d;
      if (flush_req) begin
        frames_pending <= '0;
      end else begin
        frames_pending <= frames_pending + CW'(pend_inc) - CW'(pend_dec);
      end
      if (load) begin
        data      <= load_entry[EW-1 -: DATA_WIDTH];
        out_last  <= load_entry[BW];
        data_bits <= load_entry[BW-1:0];
      end
    end
  end

  // Frame storage.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_tx_frame_source.sv
// tb_tx_frame_source: directed bench for tx_frame_source (DEPTH = 4).
// Writers push expected words into exp_q; a monitor pops on every consumed
// word. Define TX_FRAME_SOURCE_FLUSH_EN to include the flush scenario.
module tb_tx_frame_source;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 3;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] wr_data;
  logic [BW-1:0] wr_first_bits;
  logic          wr_last, wr_valid, wr_ready;
  logic [DW-1:0] data;
  logic [BW-1:0] data_bits;
  logic          data_valid, req, overflow, flush;
  logic [CW-1:0] frames_pending;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW+BW-1:0] exp_q[$];
  logic [DW+BW-1:0] mon_e;
  logic watch = 1'b0;
  int   drop_cnt = 0;

  // Clock
  always #5 clk = ~clk;

  tx_frame_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_data(wr_data), .wr_first_bits(wr_first_bits), .wr_last(wr_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .data(data), .data_bits(data_bits), .data_valid(data_valid),
    .req(req), .frames_pending(frames_pending), .overflow(overflow)
`ifdef TX_FRAME_SOURCE_FLUSH_EN
    , .flush(flush)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [BW-1:0] b);
    exp_q.push_back({d, b});
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic write_word(input logic [DW-1:0] d, input logic [BW-1:0] fb, input logic l);
    int t;
    wr_data = d; wr_first_bits = fb; wr_last = l; wr_valid = 1'b1;
    t = 0;
    while (!wr_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("wr_ready_wait", wr_ready, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  // Wait (bounded) for a word and consume it with a single-cycle req.
  task automatic take();
    int t;
    t = 0;
    while (!data_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("valid_before_req", data_valid, 1);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard monitor: compare every consumed word against exp_q.
  always @(negedge clk) begin
    if (!rst && data_valid && req) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0h/%0d expected none", data, data_bits);
      end else begin
        mon_e = exp_q.pop_front();
        check("word", {data, data_bits}, mon_e);
      end
    end
    if (watch && !data_valid) drop_cnt++;
  end

  initial begin
    rst = 1'b1; wr_data = '0; wr_first_bits = '0; wr_last = 1'b0;
    wr_valid = 1'b0; req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data, 0);
    check("rst_bits", data_bits, 0);
    check("rst_valid", data_valid, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_pending", frames_pending, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    idle(1);

    // Three-word frame, first word carries 3 valid bits.
    push_exp(8'hA5, 3'd3); push_exp(8'h3C, 3'd0); push_exp(8'h0F, 3'd0);
    write_word(8'hA5, 3'd3, 1'b0);
    write_word(8'h3C, 3'd5, 1'b0);
    write_word(8'h0F, 3'd6, 1'b1);
    check("pend_after_last", frames_pending, 1);
    check("valid_not_yet", data_valid, 0);
    idle(1);
    check("valid_rise", data_valid, 1);
    check("first_data", data, 8'hA5);
    take(); idle(1);
    take(); idle(1);
    take();
    check("valid_end_f1", data_valid, 0);
    check("pend_end_f1", frames_pending, 0);
    idle(2);

    // Two back-to-back frames, req every 4 cycles.
    push_exp(8'h31, 3'd0); push_exp(8'h32, 3'd0);
    push_exp(8'h33, 3'd5); push_exp(8'h34, 3'd0);
    write_word(8'h31, 3'd0, 1'b0);
    write_word(8'h32, 3'd0, 1'b1);
    write_word(8'h33, 3'd5, 1'b0);
    write_word(8'h34, 3'd0, 1'b1);
    check("pend_two_frames", frames_pending, 2);
    watch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(3);
      take();
      if (i == 1) check("pend_after_f_a", frames_pending, 1);
    end
    watch = 1'b0;
    check("no_valid_drop", drop_cnt, 0);
    check("pend_after_f_b", frames_pending, 0);
    check("valid_end_b2b", data_valid, 0);
    idle(2);

    // Over-long frame: 5 words with no last, then its terminating word.
    for (int i = 0; i < 5; i++) write_word(8'hE0 + 8'(i), 3'd1, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_pending", frames_pending, 0);
    check("ovf_wr_ready", wr_ready, 1);
    write_word(8'hEE, 3'd0, 1'b1);
    idle(2);
    check("ovf_no_output", data_valid, 0);
    check("ovf_pending2", frames_pending, 0);
    push_exp(8'h11, 3'd2); push_exp(8'h22, 3'd0);
    write_word(8'h11, 3'd2, 1'b0);
    write_word(8'h22, 3'd0, 1'b1);
    take(); idle(1);
    take();
    check("ovf_sticky", overflow, 1);
    check("valid_end_ovf", data_valid, 0);
    idle(2);

    // Full FIFO with one pending frame: backpressure until a req.
    push_exp(8'h55, 3'd0); push_exp(8'h66, 3'd0);
    push_exp(8'h77, 3'd1); push_exp(8'h88, 3'd0); push_exp(8'h99, 3'd0);
    write_word(8'h55, 3'd0, 1'b0);
    write_word(8'h66, 3'd0, 1'b1);
    write_word(8'h77, 3'd1, 1'b0);
    write_word(8'h88, 3'd0, 1'b0);
    check("full_backpressure", wr_ready, 0);
    check("full_pending", frames_pending, 1);
    fork
      write_word(8'h99, 3'd0, 1'b1);
      begin
        idle(2);
        check("still_full", wr_ready, 0);
        take();
      end
    join
    check("pend_two_full", frames_pending, 2);
    take(); idle(1);
    check("pend_after_66", frames_pending, 1);
    take(); idle(1);
    take(); idle(1);
    take();
    check("pend_full_done", frames_pending, 0);
    check("valid_full_done", data_valid, 0);
    idle(2);

    // Last-word write and last-word consume on the same edge.
    push_exp(8'hAA, 3'd6); push_exp(8'hBB, 3'd4);
    write_word(8'hAA, 3'd6, 1'b1);
    idle(1);
    check("single_loaded", data_valid, 1);
    wr_data = 8'hBB; wr_first_bits = 3'd4; wr_last = 1'b1; wr_valid = 1'b1; req = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0; req = 1'b0;
    check("pend_same_cycle", frames_pending, 1);
    check("valid_bypass", data_valid, 1);
    check("bypass_data", data, 8'hBB);
    check("bypass_bits", data_bits, 3'd4);
    take();
    check("pend_bypass_done", frames_pending, 0);
    check("valid_bypass_done", data_valid, 0);
    idle(2);

`ifdef TX_FRAME_SOURCE_FLUSH_EN
    // Flush while sending drops the buffered frame.
    write_word(8'hC1, 3'd2, 1'b0);
    write_word(8'hC2, 3'd0, 1'b1);
    idle(1);
    check("flush_pre_valid", data_valid, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", data_valid, 0);
    check("flush_pending", frames_pending, 0);
    check("flush_overflow", overflow, 1);
    push_exp(8'hD1, 3'd7); push_exp(8'hD2, 3'd0);
    write_word(8'hD1, 3'd7, 1'b0);
    write_word(8'hD2, 3'd0, 1'b1);
    take(); idle(1);
    take();
    check("flush_done_valid", data_valid, 0);
    idle(2);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
